// File: rtl/mips_pkg.sv
// Shared MIPS core types: MEM-stage FSM states, datapath widths, MEM/WB record.
// Pure declarations, no timing or flow control of its own.
package mips_pkg;

  localparam int WORD_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]     read_data;
    logic [WORD_W-1:0]     alu_out;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic                  memtoreg;
    logic                  regwrite;
  } mem_wb_t;

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register, loads every cycle; 1-cycle latency.
// No backpressure: the stall is applied upstream, a bubble load zeroes every field.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bubble,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (bubble) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs loads/stores on a req/ack bus, stalls upstream while busy.
// Latency 1 edge for non-memory ops, 2 + wait states for memory ops; misaligned/timeouts squash.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     MEM_ALU_out,
  input  logic [WORD_W-1:0]     MEM_register_read_data2,
  input  logic [REG_ADDR_W-1:0] MEM_register_addr,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemWrite,
  input  logic                  MEM_MemtoReg,
  input  logic                  MEM_RegWrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic [WORD_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_stall,
  output logic [WORD_W-1:0]     WB_read_data,
  output logic [WORD_W-1:0]     WB_ALU_out,
  output logic [REG_ADDR_W-1:0] WB_register_addr,
  output logic                  WB_MemtoReg,
  output logic                  WB_RegWrite,
  output logic                  mem_fault
);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              squash_q, squash_d;
  logic              fault_q, fault_d;

  logic              access;
  logic              bad_access;
  logic              start;
  logic              wb_bubble;
  mem_wb_t           wb_d, wb_q;

  assign access     = MEM_MemRead | MEM_MemWrite;
  assign bad_access = access & ((MEM_MemRead & MEM_MemWrite) | is_misaligned(MEM_ALU_out));
  assign start      = (state_q == IDLE) & access & ~bad_access;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    we_d             = we_q;
    squash_d         = squash_q;
    fault_d          = fault_q;
    wb_bubble        = 1'b0;
    wb_d.read_data   = '0;
    wb_d.alu_out     = MEM_ALU_out;
    wb_d.reg_addr    = MEM_register_addr;
    wb_d.memtoreg    = MEM_MemtoReg;
    wb_d.regwrite    = MEM_RegWrite;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          cnt_d     = '0;
          addr_d    = MEM_ALU_out;
          wdata_d   = MEM_register_read_data2;
          we_d      = MEM_MemWrite;
          rdata_d   = '0;
          squash_d  = 1'b0;
          wb_bubble = 1'b1;
        end else if (bad_access) begin
          fault_d       = 1'b1;
          wb_d.regwrite = 1'b0;
        end
      end
      BUSY: begin
        wb_bubble = 1'b1;
        // Ack is checked before the timeout so a last-cycle ack still completes cleanly.
        if (dmem_ack) begin
          if (!we_q) rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          squash_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        wb_d.read_data = rdata_q;
        if (squash_q) wb_d.regwrite = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      squash_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      squash_q <= squash_d;
      fault_q  <= fault_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (wb_bubble),
    .d_i    (wb_d),
    .q_o    (wb_q)
  );

  // Stall is combinational in IDLE, so reset must mask it while a memory op sits on the inputs.
  assign mem_stall        = rst_n & (start | (state_q == BUSY));
  assign dmem_req         = (state_q == BUSY);
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign mem_fault        = fault_q;
  assign WB_read_data     = wb_q.read_data;
  assign WB_ALU_out       = wb_q.alu_out;
  assign WB_register_addr = wb_q.reg_addr;
  assign WB_MemtoReg      = wb_q.memtoreg;
  assign WB_RegWrite      = wb_q.regwrite;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected MEM/WB records queued per instruction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] MEM_ALU_out, MEM_register_read_data2;
  logic [4:0]  MEM_register_addr;
  logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall;
  logic [31:0] WB_read_data, WB_ALU_out;
  logic [4:0]  WB_register_addr;
  logic        WB_MemtoReg, WB_RegWrite, mem_fault;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .MEM_ALU_out             (MEM_ALU_out),
    .MEM_register_read_data2 (MEM_register_read_data2),
    .MEM_register_addr       (MEM_register_addr),
    .MEM_MemRead             (MEM_MemRead),
    .MEM_MemWrite            (MEM_MemWrite),
    .MEM_MemtoReg            (MEM_MemtoReg),
    .MEM_RegWrite            (MEM_RegWrite),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_addr               (dmem_addr),
    .dmem_wdata              (dmem_wdata),
    .dmem_rdata              (dmem_rdata),
    .dmem_ack                (dmem_ack),
    .mem_stall               (mem_stall),
    .WB_read_data            (WB_read_data),
    .WB_ALU_out              (WB_ALU_out),
    .WB_register_addr        (WB_register_addr),
    .WB_MemtoReg             (WB_MemtoReg),
    .WB_RegWrite             (WB_RegWrite),
    .mem_fault               (mem_fault)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  ra;
    logic        m2r;
    logic        rw;
    int          req;
    int          stall;
    logic        fault;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Memory model / monitor state, owned by the responder process.
  int          ack_wait   = -1;
  logic [31:0] rdata_val  = 32'h0;
  logic        force_ack  = 1'b0;
  int          req_cycles = 0;
  int          stall_cycles = 0;
  logic [31:0] seen_addr  = 32'h0;
  logic [31:0] seen_wdata = 32'h0;
  logic        seen_we    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  initial begin : responder
    int wait_cnt;
    wait_cnt   = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (mem_stall) stall_cycles++;
      if (dmem_req) begin
        req_cycles++;
        seen_addr  = dmem_addr;
        seen_wdata = dmem_wdata;
        seen_we    = dmem_we;
        if (wait_cnt == ack_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata_val;
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = 32'hBAD0BAD0;
        end
        wait_cnt++;
      end else begin
        dmem_ack   = force_ack;
        dmem_rdata = 32'hBAD0BAD0;
        wait_cnt   = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    MEM_ALU_out             = alu;
    MEM_register_read_data2 = wd;
    MEM_register_addr       = ra;
    MEM_MemRead             = mr;
    MEM_MemWrite            = mw;
    MEM_MemtoReg            = m2r;
    MEM_RegWrite            = rw;
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] ra,
                              input logic m2r, input logic rw, input int req, input int stall,
                              input logic fault, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic we);
    exp_t e;
    e.rd = rd; e.alu = alu; e.ra = ra; e.m2r = m2r; e.rw = rw; e.req = req; e.stall = stall;
    e.fault = fault; e.addr = addr; e.wdata = wdata; e.we = we;
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] ra, input logic mr, input logic mw, input logic m2r,
                        input logic rw, input int wt, input logic [31:0] rdv, input exp_t e);
    exp_t x;
    bit   done;
    int   req0, stall0;
    sb.push_back(e);
    @(posedge clk); #1;
    ack_wait  = wt;
    rdata_val = rdv;
    req0      = req_cycles;
    stall0    = stall_cycles;
    drive(alu, wd, ra, mr, mw, m2r, rw);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (!mem_stall) done = 1'b1;
    end
    check_eq({tag, "/stall_release"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    x = sb.pop_front();
    check_eq({tag, "/WB_read_data"},     WB_read_data,            x.rd);
    check_eq({tag, "/WB_ALU_out"},       WB_ALU_out,              x.alu);
    check_eq({tag, "/WB_register_addr"}, 32'(WB_register_addr),   32'(x.ra));
    check_eq({tag, "/WB_MemtoReg"},      32'(WB_MemtoReg),        32'(x.m2r));
    check_eq({tag, "/WB_RegWrite"},      32'(WB_RegWrite),        32'(x.rw));
    check_eq({tag, "/req_cycles"},       32'(req_cycles - req0),  32'(x.req));
    check_eq({tag, "/stall_cycles"},     32'(stall_cycles - stall0), 32'(x.stall));
    check_eq({tag, "/mem_fault"},        32'(mem_fault),          32'(x.fault));
    if (x.req > 0) begin
      check_eq({tag, "/dmem_addr"},  seen_addr,        x.addr);
      check_eq({tag, "/dmem_wdata"}, seen_wdata,       x.wdata);
      check_eq({tag, "/dmem_we"},    32'(seen_we),     32'(x.we));
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq({tag, "/fault_cleared"}, 32'(mem_fault), 32'd0);
  endtask

  initial begin : stim
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_eq("rst/dmem_req",   32'(dmem_req),   32'd0);
    check_eq("rst/mem_stall",  32'(mem_stall),  32'd0);
    check_eq("rst/mem_fault",  32'(mem_fault),  32'd0);
    check_eq("rst/WB_ALU_out", WB_ALU_out,      32'd0);
    check_eq("rst/WB_RegWrite", 32'(WB_RegWrite), 32'd0);
    check_eq("rst/dmem_addr",  dmem_addr,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("alu", 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,
           mk(32'h0, 32'h1234, 5'd5, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0));
    run_op("load3w", 32'h100, 32'hAAAA0000, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF,
           mk(32'hDEADBEEF, 32'h100, 5'd3, 1'b1, 1'b1, 4, 5, 1'b0, 32'h100, 32'hAAAA0000, 1'b0));
    run_op("store0w", 32'h204, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h11111111,
           mk(32'h0, 32'h204, 5'd0, 1'b0, 1'b0, 1, 2, 1'b0, 32'h204, 32'hCAFEF00D, 1'b1));
    run_op("ack_at_limit", 32'h40, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 14, 32'h0BADF00D,
           mk(32'h0BADF00D, 32'h40, 5'd9, 1'b1, 1'b1, 15, 16, 1'b0, 32'h40, 32'h0, 1'b0));
    run_op("misaligned", 32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h12345678,
           mk(32'h0, 32'h102, 5'd7, 1'b1, 1'b0, 0, 0, 1'b1, 32'h0, 32'h0, 1'b0));
    run_op("sticky", 32'h99, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,
           mk(32'h0, 32'h99, 5'd4, 1'b0, 1'b1, 0, 0, 1'b1, 32'h0, 32'h0, 1'b0));

    pulse_reset("rst1");
    run_op("rd_and_wr", 32'h10, 32'h5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'h0,
           mk(32'h0, 32'h10, 5'd6, 1'b1, 1'b0, 0, 0, 1'b1, 32'h0, 32'h0, 1'b0));

    pulse_reset("rst2");
    run_op("timeout", 32'h80, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, -1, 32'h0,
           mk(32'h0, 32'h80, 5'd10, 1'b1, 1'b0, 15, 16, 1'b1, 32'h80, 32'h0, 1'b0));
    force_ack = 1'b1;
    run_op("spurious_ack", 32'h55, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,
           mk(32'h0, 32'h55, 5'd2, 1'b0, 1'b1, 0, 0, 1'b1, 32'h0, 32'h0, 1'b0));
    force_ack = 1'b0;

    // Asynchronous reset landing in the second BUSY cycle of a load.
    @(posedge clk); #1;
    ack_wait = -1;
    drive(32'h300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("midrst/pre_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst/dmem_req",   32'(dmem_req),   32'd0);
    check_eq("midrst/mem_stall",  32'(mem_stall),  32'd0);
    check_eq("midrst/mem_fault",  32'(mem_fault),  32'd0);
    check_eq("midrst/WB_all", {WB_read_data ^ WB_ALU_out, 32'(WB_register_addr)} == 64'h0 &&
             !WB_MemtoReg && !WB_RegWrite ? 32'd0 : 32'd1, 32'd0);
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op("post_rst_load", 32'h308, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h13572468,
           mk(32'h13572468, 32'h308, 5'd11, 1'b1, 1'b1, 2, 3, 1'b0, 32'h308, 32'h0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
